// File: rtl/sad_search_if.sv
// Handshake and result bus between the frame-fetch controller, the SAD search
// stage and the motion-vector consumer.
interface sad_search_if #(
  parameter int PIX_W = 8,
  parameter int BLK   = 8,
  parameter int RANGE = 4
);
  localparam int WIN   = BLK + 2 * RANGE;
  localparam int SAD_W = PIX_W + 2 * $clog2(BLK);
  localparam int MV_W  = $clog2(RANGE) + 2;

  logic                    start;
  logic                    busy;
  logic                    in_valid;
  logic                    in_ready;
  logic [WIN*PIX_W-1:0]    in_data;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [MV_W-1:0] mv_x;
  logic signed [MV_W-1:0] mv_y;
  logic [SAD_W-1:0]        sad_min;

  modport master (
    output start, in_valid, in_data, out_ready,
    input  busy, in_ready, out_valid, mv_x, mv_y, sad_min
  );

  modport slave (
    input  start, in_valid, in_data, out_ready,
    output busy, in_ready, out_valid, mv_x, mv_y, sad_min
  );
endinterface

// File: rtl/sad_search.sv
// Exhaustive full-search SAD motion estimation: loads one block and its search
// window row by row, then evaluates one (candidate, row) pair per cycle.
module sad_search #(
  parameter int PIX_W = 8,
  parameter int BLK   = 8,
  parameter int RANGE = 4
) (
  input logic         clk,
  input logic         rst_n,
  sad_search_if.slave bus
);
  localparam int WIN   = BLK + 2 * RANGE;
  localparam int SAD_W = PIX_W + 2 * $clog2(BLK);
  localparam int MV_W  = $clog2(RANGE) + 2;
  localparam int RS_W  = PIX_W + $clog2(BLK);
  localparam int BW    = BLK * PIX_W;
  localparam int RW    = $clog2(BLK);
  localparam int CW    = $clog2(2 * RANGE + 1);
  localparam int LW    = $clog2(WIN);

  localparam logic [RW-1:0] R_LAST   = RW'(BLK - 1);
  localparam logic [CW-1:0] C_LAST   = CW'(2 * RANGE);
  localparam logic [LW-1:0] CUR_LAST = LW'(BLK - 1);
  localparam logic [LW-1:0] REF_LAST = LW'(WIN - 1);

  typedef enum logic [2:0] {IDLE, LOAD_CUR, LOAD_REF, SEARCH, DONE} state_t;

  state_t                  state_q;
  logic                    busy_q, in_ready_q, out_valid_q, issue_q, vld_p0;
  logic [LW-1:0]           ld_cnt_q;
  logic [RW-1:0]           r_q;
  logic [CW-1:0]           dx_q, dy_q, bdx_q, bdy_q, dx_p0, dy_p0;
  logic [SAD_W-1:0]        acc_q, best_q, sad_min_q;
  logic signed [MV_W-1:0] mv_x_q, mv_y_q;
  logic [RS_W-1:0]         rsum_p0;
  logic                    last_p0, final_p0;
  logic [BW-1:0]           cur_q [BLK];
  logic [WIN*PIX_W-1:0]    ref_q [WIN];

  logic [LW-1:0]           ref_idx;
  logic [BW-1:0]           ref_win;
  logic [RS_W-1:0]         rsum_d;
  logic [SAD_W-1:0]        acc_d, best_d;
  logic [CW-1:0]           bdx_d, bdy_d;
  logic                    take;

  function automatic logic [RS_W-1:0] row_sad(input logic [BW-1:0] a,
                                              input logic [BW-1:0] b);
    logic [RS_W-1:0]        s;
    logic signed [PIX_W:0] d;
    s = '0;
    for (int c = 0; c < BLK; c++) begin
      d = $signed({1'b0, a[c*PIX_W +: PIX_W]}) - $signed({1'b0, b[c*PIX_W +: PIX_W]});
      s = s + RS_W'(d[PIX_W] ? -d : d);
    end
    return s;
  endfunction

  // Stage p0 input: window row dy+r shifted so column dx lands at pixel 0
  always_comb begin
    ref_idx = LW'(dy_q) + LW'(r_q);
    ref_win = BW'(ref_q[ref_idx] >> (int'(dx_q) * PIX_W));
    rsum_d  = row_sad(cur_q[r_q], ref_win);
    acc_d   = acc_q + SAD_W'(rsum_p0);
    take    = last_p0 && (acc_d < best_q);
    best_d  = take ? acc_d : best_q;
    bdx_d   = take ? dx_p0 : bdx_q;
    bdy_d   = take ? dy_p0 : bdy_q;
  end

  always_ff @(posedge clk) begin
    if (state_q == LOAD_CUR && bus.in_valid)
      cur_q[ld_cnt_q[RW-1:0]] <= bus.in_data[BW-1:0];
    if (state_q == LOAD_REF && bus.in_valid)
      ref_q[ld_cnt_q] <= bus.in_data;
    rsum_p0  <= rsum_d;
    dx_p0    <= dx_q;
    dy_p0    <= dy_q;
    last_p0  <= (r_q == R_LAST);
    final_p0 <= (r_q == R_LAST) && (dx_q == C_LAST) && (dy_q == C_LAST);
  end

  // Stage p1: accumulate row sums, compare on each candidate's last row
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      busy_q      <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      mv_x_q      <= '0;
      mv_y_q      <= '0;
      sad_min_q   <= '0;
      ld_cnt_q    <= '0;
      r_q         <= '0;
      dx_q        <= '0;
      dy_q        <= '0;
      issue_q     <= 1'b0;
      vld_p0      <= 1'b0;
      acc_q       <= '0;
      best_q      <= '1;
      bdx_q       <= '0;
      bdy_q       <= '0;
    end else begin
      vld_p0 <= issue_q;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            state_q    <= LOAD_CUR;
            busy_q     <= 1'b1;
            in_ready_q <= 1'b1;
            ld_cnt_q   <= '0;
            acc_q      <= '0;
            best_q     <= '1;
          end
        end
        LOAD_CUR: begin
          if (bus.in_valid) begin
            if (ld_cnt_q == CUR_LAST) begin
              state_q  <= LOAD_REF;
              ld_cnt_q <= '0;
            end else begin
              ld_cnt_q <= ld_cnt_q + 1'b1;
            end
          end
        end
        LOAD_REF: begin
          if (bus.in_valid) begin
            if (ld_cnt_q == REF_LAST) begin
              state_q    <= SEARCH;
              in_ready_q <= 1'b0;
              ld_cnt_q   <= '0;
              issue_q    <= 1'b1;
              r_q        <= '0;
              dx_q       <= '0;
              dy_q       <= '0;
            end else begin
              ld_cnt_q <= ld_cnt_q + 1'b1;
            end
          end
        end
        SEARCH: begin
          if (issue_q) begin
            if (r_q == R_LAST) begin
              r_q <= '0;
              if (dx_q == C_LAST) begin
                dx_q <= '0;
                if (dy_q == C_LAST) begin
                  dy_q    <= '0;
                  issue_q <= 1'b0;
                end else begin
                  dy_q <= dy_q + 1'b1;
                end
              end else begin
                dx_q <= dx_q + 1'b1;
              end
            end else begin
              r_q <= r_q + 1'b1;
            end
          end
          if (vld_p0) begin
            acc_q  <= last_p0 ? '0 : acc_d;
            best_q <= best_d;
            bdx_q  <= bdx_d;
            bdy_q  <= bdy_d;
            if (final_p0) begin
              state_q     <= DONE;
              out_valid_q <= 1'b1;
              mv_x_q      <= MV_W'(bdx_d) - MV_W'(RANGE);
              mv_y_q      <= MV_W'(bdy_d) - MV_W'(RANGE);
              sad_min_q   <= best_d;
            end
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy      = busy_q;
  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.mv_x      = mv_x_q;
  assign bus.mv_y      = mv_y_q;
  assign bus.sad_min   = sad_min_q;
endmodule

// File: doc/sad_search.md
Name: sad_search

Overview:
- Motion-estimation search stage directly downstream of the frame-fetch controller.
- Accepts one current block and its reference search window as a stream of 128-bit SRAM-word rows.
- Runs an exhaustive full-search SAD (sum of absolute differences) over every candidate displacement and returns the best motion vector and its SAD.
- Feeds the motion-vector consumer through a valid/ready output.

Parameters:
- PIX_W, 8: bits per luma pixel.
- BLK, 8: block edge in pixels (block is BLK x BLK).
- RANGE, 4: search range ±RANGE pixels in x and y.
- Derived, not overridable:
  - WIN = BLK+2*RANGE (16), window edge in pixels.
  - NCAND = (2*RANGE+1)^2 (81).
  - SAD_W = PIX_W+2*clog2(BLK) (14).
  - MV_W = clog2(RANGE)+2 (4).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; begins a new search; honoured only in IDLE
- busy  out  1  high in any state other than IDLE
- in_valid  in  1  input row valid
- in_ready  out  1  block can accept a row
- in_data  in  WIN*PIX_W (128)  row data; pixel i at bits [i*PIX_W +: PIX_W], pixel 0 = leftmost column
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- mv_x  out  MV_W  signed two's-complement horizontal vector, -RANGE..+RANGE
- mv_y  out  MV_W  signed vertical vector, -RANGE..+RANGE
- sad_min  out  SAD_W  SAD of the winning candidate

Behaviour:
- Reset (asynchronous, rst_n low):
  - State goes to IDLE.
  - busy, in_ready, out_valid, mv_x, mv_y, sad_min and all counters are 0.
  - Best-SAD register is set to all-ones.
- States: IDLE -> LOAD_CUR -> LOAD_REF -> SEARCH -> DONE -> IDLE.
- IDLE:
  - start=1 moves to LOAD_CUR next cycle; otherwise stays.
  - in_ready=0 and in_valid is ignored.
- LOAD_CUR:
  - in_ready=1. Each handshake (in_valid & in_ready) stores in_data[BLK*PIX_W-1:0] as current row r, r=0..BLK-1.
  - Upper bits are ignored.
  - After row BLK-1 is accepted, moves to LOAD_REF.
  - in_valid gaps stall with no state change.
- LOAD_REF:
  - in_ready=1. Each handshake stores the full in_data as window row r, r=0..WIN-1.
  - After row WIN-1 is accepted, moves to SEARCH.
  - in_ready drops in the cycle after the final accepted row.
- SEARCH:
  - One (candidate, row) pair per cycle: BLK absolute differences |cur[r][c] - ref[dy+r][dx+c]| are summed and added to the running candidate SAD.
  - Candidates run in raster order: dy=0..2R outer, dx=0..2R inner, r=0..BLK-1 innermost.
  - Duration is exactly NCAND*BLK cycles (648).
- Compare and tie rules:
  - On completing a candidate's final row, its SAD replaces the best if strictly less.
  - On a tie, the earlier raster candidate wins.
  - The first candidate always wins against the all-ones initial best.
- Arithmetic:
  - Absolute differences are unsigned PIX_W bits; the row sum is PIX_W+clog2(BLK) bits; the accumulator is SAD_W bits.
  - Maximum SAD is BLK*BLK*(2^PIX_W-1) = 16320, so no overflow or saturation is needed.
- DONE:
  - out_valid=1 in the first DONE cycle, which is exactly NCAND*BLK+1 = 649 cycles after the edge of the final LOAD_REF handshake.
  - mv_x = dx_best-RANGE, mv_y = dy_best-RANGE, sad_min = best SAD.
  - Outputs hold stable while out_ready=0.
  - On the out_valid&out_ready edge: out_valid goes to 0 and the state returns to IDLE. mv_x, mv_y and sad_min keep their values until the next DONE.
- start outside IDLE is ignored, including the DONE cycle of the handshake; start in the first IDLE cycle is accepted.
- Reset asserted mid-operation at any state aborts immediately to reset values. Partially loaded data is discarded and a fresh start is required.
- in_valid while in_ready=0 is ignored; no data is captured.

Test Plan:
- Matching block: window = 0xFF everywhere except the centre 8x8 at (4,4), which equals a cur block of ramp pixels (r*8+c) -> mv_x=0, mv_y=0, sad_min=0, out_valid exactly 649 cycles after the last ref row.
- Offset match: cur copied into window at column 7, row 2; rest of window random but ≥1 different per candidate -> mv_x=+3, mv_y=-2, sad_min=0.
- Ties: cur and window all zero -> every SAD is 0; the first candidate wins: mv_x=-4, mv_y=-4, sad_min=0.
- Max SAD: cur all 0xFF, window all 0x00 -> sad_min=16320 (0x3FC0), mv_x=-4, mv_y=-4; no overflow.
- Flow control:
  - Random in_valid gaps during both load phases give the same result as gapless input.
  - out_ready held low for 10 DONE cycles keeps outputs stable and out_valid high.
  - start pulsed during SEARCH has no effect.
  - in_valid asserted in IDLE captures nothing.
- Reset mid-SEARCH (cycle 300): all outputs 0 and busy=0 immediately. A subsequent full run with the offset-match vectors returns mv_x=+3, mv_y=-2, sad_min=0.
